// File: rtl/cnn_pkg.sv
// Shared constants and helpers for the FP16 CNN datapath blocks.
package cnn_pkg;

  localparam int          FP16_W    = 16;
  localparam logic [15:0] FP16_ZERO = 16'h0000;
  localparam logic [15:0] FP16_ONE  = 16'h3C00;
  localparam logic [15:0] FP16_QNAN = 16'h7E00;
  localparam logic [15:0] FP16_PINF = 16'h7C00;
  localparam logic [15:0] FP16_NINF = 16'hFC00;

  // Role of the pixel currently presented on the input stream.
  typedef enum logic [1:0] {
    PH_EVEN_ROW,  // store into the row buffer
    PH_ODD_HOLD,  // left column of a window on the odd row
    PH_ODD_FIRE   // right column of a window on the odd row: window complete
  } phase_t;

  // Width of a counter running 0..n-1 (never narrower than one bit).
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/avg.sv
// Combinational FP16 mean of four operands: exact sum, divide by four,
// one round-to-nearest-even. NaN or (+Inf and -Inf) gives quiet NaN.
module avg import cnn_pkg::*; (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  output logic [15:0] avgout
);

  // Exact signed fixed-point value of a finite FP16 in units of 2^-24.
  function automatic logic signed [43:0] to_fix(input logic [15:0] x);
    logic [43:0] m;
    if (x[14:10] == 5'd0) m = {34'd0, x[9:0]};
    else                  m = {33'd0, 1'b1, x[9:0]} << (x[14:10] - 5'd1);
    return x[15] ? $signed(-m) : $signed(m);
  endfunction

  logic [15:0]        ops [4];
  logic signed [43:0] sum;
  logic [43:0]        mag;      // |sum|, read as |sum/4| in units of 2^-26
  logic [5:0]         p;        // leading-one position of mag
  logic [5:0]         sh;
  logic [9:0]         kept;
  logic               guard, sticky;
  logic [14:0]        enc;
  logic               nan_any, pinf_any, ninf_any, all_nzero;

  // Exact accumulate, normalise, round once, then apply special-value rules.
  // NOTE: every variable gets a default at the top so no path leaves one unassigned (no latches).
  always_comb begin
    ops[0] = a; ops[1] = b; ops[2] = c; ops[3] = d;
    nan_any = 1'b0; pinf_any = 1'b0; ninf_any = 1'b0; all_nzero = 1'b1;
    sh = 6'd0; kept = 10'd0; guard = 1'b0; sticky = 1'b0; enc = 15'd0;
    for (int k = 0; k < 4; k++) begin
      if (ops[k][14:10] == 5'h1F && ops[k][9:0] != 10'd0) nan_any = 1'b1;
      if (ops[k] == FP16_PINF) pinf_any = 1'b1;
      if (ops[k] == FP16_NINF) ninf_any = 1'b1;
      if (ops[k] != 16'h8000) all_nzero = 1'b0;
    end

    sum = to_fix(a) + to_fix(b) + to_fix(c) + to_fix(d);
    mag = sum[43] ? 44'(-sum) : 44'(sum);
    p   = 6'd0;
    for (int i = 0; i < 44; i++) if (mag[i]) p = 6'(i);

    if (p < 6'd12) begin
      // Below 2^-14: subnormal grid of 2^-24, i.e. drop two bits.
      guard  = mag[1];
      sticky = mag[0];
      enc    = {5'd0, mag[11:2]} + 15'(guard && (sticky || mag[2]));
    end else begin
      // Normal: keep 11 significant bits; carry may ripple into the exponent.
      sh     = p - 6'd10;
      kept   = 10'(mag >> sh);
      guard  = mag[sh - 6'd1];
      sticky = |(mag & ((44'd1 << (sh - 6'd1)) - 44'd1));
      enc    = {5'(p - 6'd11), kept} + 15'(guard && (sticky || kept[0]));
      if (enc > 15'h7C00) enc = 15'h7C00;
    end

    if (nan_any || (pinf_any && ninf_any)) avgout = FP16_QNAN;
    else if (pinf_any)                     avgout = FP16_PINF;
    else if (ninf_any)                     avgout = FP16_NINF;
    else if (sum == 44'sd0)                avgout = all_nzero ? 16'h8000 : FP16_ZERO;
    else                                   avgout = {sum[43], enc};
  end

endmodule

// File: rtl/line_buf_1r1w.sv
// One-row pixel buffer: one synchronous write port, two combinational read ports.
module line_buf_1r1w import cnn_pkg::*; #(
  parameter int DEPTH  = 24,
  parameter int DATA_W = 16,
  parameter int AW     = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr0,
  output logic [DATA_W-1:0] rdata0,
  input  logic [AW-1:0]     raddr1,
  output logic [DATA_W-1:0] rdata1
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write the even-row pixel into its column slot.
  // NOTE: sequential state is always updated with <= so every flop samples pre-edge values.
  // NOTE: the storage array has no reset; every slot is rewritten on the even row before
  //       it is read on the odd row, so clearing it would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/avgpool2x2_ctrl.sv
// 2x2 stride-2 average pooling sequencer for one FP16 channel in raster order.
module avgpool2x2_ctrl import cnn_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 24,
  parameter int IMG_H  = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_done
);

  localparam int COL_W  = cnt_w(IMG_W);
  localparam int ROW_W  = cnt_w(IMG_H);
  localparam int N_OUT  = (IMG_W / 2) * (IMG_H / 2);
  localparam int OCNT_W = cnt_w(N_OUT);

  if (DATA_W != FP16_W || IMG_W < 2 || IMG_H < 2 || (IMG_W % 2) != 0 || (IMG_H % 2) != 0)
  begin : g_bad_params
    $fatal(1, "avgpool2x2_ctrl: DATA_W must be 16, IMG_W and IMG_H even and >= 2");
  end

  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [OCNT_W-1:0] ocnt;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] rb_left, rb_right, avg_res;
  phase_t            phase;
  logic              in_acc, out_acc, fire, col_last, row_last;

  // A single output slot: input stalls whenever that slot cannot drain this cycle.
  assign in_ready = rst_n && (!out_valid || out_ready);
  assign in_acc   = in_valid && in_ready;
  assign out_acc  = out_valid && out_ready;
  assign col_last = (col == COL_W'(IMG_W - 1));
  assign row_last = (row == ROW_W'(IMG_H - 1));
  assign fire     = in_acc && (phase == PH_ODD_FIRE);

  // Decode the pixel's role from the parity of its coordinates.
  always_comb begin
    phase = PH_EVEN_ROW;
    if (row[0]) phase = col[0] ? PH_ODD_FIRE : PH_ODD_HOLD;
  end

  // Raster position of the next input pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (in_acc) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Left pixel of the window on the odd row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             hold <= '0;
    else if (in_acc && phase == PH_ODD_HOLD) hold <= in_data;
  end

  line_buf_1r1w #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_rowbuf (
    .clk    (clk),
    .we     (in_acc && phase == PH_EVEN_ROW),
    .waddr  (col),
    .wdata  (in_data),
    .raddr0 (col & ~COL_W'(1)),
    .rdata0 (rb_left),
    .raddr1 (col),
    .rdata1 (rb_right)
  );

  avg u_avg (rb_left, rb_right, hold, in_data, avg_res);

  // Output slot: a firing window loads it, otherwise acceptance empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (fire) begin
      out_valid <= 1'b1;
      out_data  <= avg_res;
    end else if (out_acc) begin
      out_valid <= 1'b0;
    end
  end

  // Count accepted outputs and pulse once the last one of the frame leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ocnt       <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (out_acc) begin
        if (ocnt == OCNT_W'(N_OUT - 1)) begin
          ocnt       <= '0;
          frame_done <= 1'b1;
        end else begin
          ocnt <= ocnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_avgpool2x2_ctrl.sv
// Self-checking bench for avgpool2x2_ctrl on a 4x4 frame: real-valued pooling model + scoreboard.
module tb_avgpool2x2_ctrl;
  import cnn_pkg::*;

  localparam int W = 4, H = 4, NOUT = (W / 2) * (H / 2);

  logic        clk = 1'b0, rst_n = 1'b1;
  logic [15:0] in_data = '0, out_data;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, frame_done;
  logic [15:0] ra = '0, rb = '0, rc = '0, rd = '0, rout;

  int total = 0, bad = 0;
  int n_out = 0, n_fd = 0, rdy_mode = 0;
  logic [15:0] exp_q [$];
  logic [15:0] got_q [$];
  logic [15:0] pix [H][W];
  int mr = 0, mc = 0, ocnt_m = 0;
  logic fd_pend = 1'b0;
  logic [15:0] fr [W*H];
  logic [15:0] first_run [$];

  always #5 clk = ~clk;

  avgpool2x2_ctrl #(.DATA_W(16), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .frame_done(frame_done)
  );

  avg u_ref (.a(ra), .b(rb), .c(rc), .d(rd), .avgout(rout));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference arithmetic (plain reals) ----------------
  function automatic real pow2(input int n);
    real r = 1.0;
    if (n >= 0) repeat (n) r = r * 2.0;
    else        repeat (-n) r = r / 2.0;
    return r;
  endfunction

  function automatic real fp_val(input logic [15:0] x);
    int e = int'(x[14:10]);
    int m = int'(x[9:0]);
    real v = (e == 0) ? m * pow2(-24) : (1024 + m) * pow2(e - 25);
    return x[15] ? -v : v;
  endfunction

  function automatic int rne(input real v);
    real f = $floor(v);
    real r = v - f;
    int  q = $rtoi(f);
    if (r > 0.5 || (r == 0.5 && (q % 2) == 1)) q++;
    return q;
  endfunction

  function automatic logic [15:0] model_avg(input logic [15:0] a, b, c, d);
    logic [15:0] o [4];
    logic nan = 0, pinf = 0, ninf = 0, allnz = 1, sgn;
    real s = 0.0, x;
    int e, q;
    logic [15:0] enc;
    o[0] = a; o[1] = b; o[2] = c; o[3] = d;
    foreach (o[k]) begin
      if (o[k][14:10] == 5'h1F && o[k][9:0] != 0) nan = 1;
      else if (o[k] == 16'h7C00) pinf = 1;
      else if (o[k] == 16'hFC00) ninf = 1;
      if (o[k] != 16'h8000) allnz = 0;
    end
    if (nan || (pinf && ninf)) return 16'h7E00;
    if (pinf) return 16'h7C00;
    if (ninf) return 16'hFC00;
    foreach (o[k]) s = s + fp_val(o[k]);
    if (s == 0.0) return allnz ? 16'h8000 : 16'h0000;
    sgn = (s < 0.0);
    x = (sgn ? -s : s) / 4.0;
    if (x < pow2(-14)) begin
      enc = 16'(rne(x * pow2(24)));
    end else begin
      e = -14;
      while (x >= pow2(e + 1)) e++;
      q = rne(x * pow2(10 - e));
      if (q == 2048) begin q = 1024; e++; end
      enc = (e > 15) ? 16'h7C00 : 16'((e + 15) * 1024 + (q - 1024));
    end
    return {sgn, enc[14:0]};
  endfunction

  function automatic logic [15:0] rand_px();
    logic [15:0] sp [8];
    sp[0] = 16'h7C00; sp[1] = 16'hFC00; sp[2] = 16'h7E00; sp[3] = 16'h0000;
    sp[4] = 16'h8000; sp[5] = 16'h0001; sp[6] = 16'h8001; sp[7] = 16'h7BFF;
    case ($urandom_range(15))
      0:       return 16'($urandom);
      1:       return sp[$urandom_range(7)];
      default: return {1'($urandom), 5'($urandom_range(22)), 10'($urandom)};
    endcase
  endfunction

  // ---------------- single compare process ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_out_valid", {31'd0, out_valid}, 0);
      check("rst_out_data", {16'd0, out_data}, 0);
      check("rst_frame_done", {31'd0, frame_done}, 0);
      check("rst_in_ready", {31'd0, in_ready}, 0);
      exp_q.delete();
      mr = 0; mc = 0; ocnt_m = 0; fd_pend = 1'b0;
    end else begin
      check("in_ready", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
      check("frame_done", {31'd0, frame_done}, {31'd0, fd_pend});
      if (frame_done) n_fd++;
      check("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
      if (out_valid && exp_q.size() != 0) check("out_data", {16'd0, out_data}, {16'd0, exp_q[0]});
      fd_pend = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got_q.push_back(out_data);
        n_out++;
        if (ocnt_m == NOUT - 1) begin ocnt_m = 0; fd_pend = 1'b1; end
        else ocnt_m++;
      end
      if (in_valid && in_ready) begin
        pix[mr][mc] = in_data;
        if ((mr % 2) == 1 && (mc % 2) == 1)
          exp_q.push_back(model_avg(pix[mr-1][mc-1], pix[mr-1][mc], pix[mr][mc-1], in_data));
        if (mc == W - 1) begin mc = 0; mr = (mr == H - 1) ? 0 : mr + 1; end
        else mc++;
      end
    end
  end

  // ---------------- out_ready driver ----------------
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_px(input logic [15:0] d, input int idle_pct);
    logic acc = 1'b0;
    while ($urandom_range(99) < idle_pct) begin in_valid = 1'b0; @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = d;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      if (acc) break;
    end
    if (!acc) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int idle_pct);
    for (int i = 0; i < W*H; i++) send_px(fr[i], idle_pct);
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() != 0 || out_valid) && k < 300) begin @(posedge clk); #1; k++; end
    if (k >= 300) check("drain_timeout", 0, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  int n0, f0;

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Pin the reference model with hand-computed values.
    check("model_ones", {16'd0, model_avg(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00)}, 32'h3C00);
    check("model_1234", {16'd0, model_avg(16'h3C00, 16'h4000, 16'h4200, 16'h4400)}, 32'h4100);
    check("model_mixed", {16'd0, model_avg(16'h39D2, 16'h35A1, 16'hB0A3, 16'h475E)}, 32'h4027);
    check("model_nan", {16'd0, model_avg(16'h7C00, 16'hFC00, 16'h0000, 16'h0000)}, 32'h7E00);

    // 1: all-ones frame.
    foreach (fr[i]) fr[i] = FP16_ONE;
    got_q.delete(); n0 = n_out; f0 = n_fd;
    send_frame(0); drain();
    check("t1_count", n_out - n0, 4);
    check("t1_fd", n_fd - f0, 1);
    foreach (got_q[i]) check("t1_val", {16'd0, got_q[i]}, 32'h3C00);

    // 2: 1,2,3,4 top-left window, zeros elsewhere.
    foreach (fr[i]) fr[i] = 16'h0000;
    fr[0] = 16'h3C00; fr[1] = 16'h4000; fr[W] = 16'h4200; fr[W+1] = 16'h4400;
    got_q.delete();
    send_frame(0); drain();
    check("t2_count", got_q.size(), 4);
    if (got_q.size() == 4) begin
      check("t2_out0", {16'd0, got_q[0]}, 32'h4100);
      for (int i = 1; i < 4; i++) check("t2_zero", {16'd0, got_q[i]}, 32'h0000);
    end

    // 3: mixed window against a standalone avg instance.
    foreach (fr[i]) fr[i] = rand_px();
    fr[0] = 16'h39D2; fr[1] = 16'h35A1; fr[W] = 16'hB0A3; fr[W+1] = 16'h475E;
    ra = 16'h39D2; rb = 16'h35A1; rc = 16'hB0A3; rd = 16'h475E;
    got_q.delete();
    send_frame(0); drain();
    check("t3_ref_lit", {16'd0, rout}, 32'h4027);
    if (got_q.size() > 0) check("t3_dut_vs_ref", {16'd0, got_q[0]}, {16'd0, rout});
    else check("t3_no_output", 0, 1);

    // 4: backpressure, then the same frame without stall.
    foreach (fr[i]) fr[i] = rand_px();
    got_q.delete(); rdy_mode = 2;
    fork
      send_frame(0);
      begin
        int k = 0;
        while (!out_valid && k < 200) begin @(posedge clk); #1; k++; end
        if (k >= 200) check("t4_wait_valid", 0, 1);
        repeat (5) @(posedge clk);
        #1 rdy_mode = 0;
      end
    join
    drain();
    first_run = got_q;
    got_q.delete();
    send_frame(0); drain();
    check("t4_count", first_run.size(), 4);
    check("t4_count_ref", got_q.size(), 4);
    if (first_run.size() == got_q.size())
      foreach (got_q[i]) check("t4_same_seq", {16'd0, first_run[i]}, {16'd0, got_q[i]});

    // 5: two frames back to back, second all ones.
    got_q.delete(); n0 = n_out; f0 = n_fd;
    foreach (fr[i]) fr[i] = rand_px();
    send_frame(0);
    foreach (fr[i]) fr[i] = FP16_ONE;
    send_frame(0); drain();
    check("t5_count", n_out - n0, 8);
    check("t5_fd", n_fd - f0, 2);
    if (got_q.size() == 8) for (int i = 4; i < 8; i++) check("t5_frame2", {16'd0, got_q[i]}, 32'h3C00);

    // 6: reset at row 1 col 2, then a fresh all-ones frame.
    for (int i = 0; i < W + 2; i++) send_px(rand_px(), 0);
    repeat (2) @(posedge clk);
    #1 do_reset();
    got_q.delete(); n0 = n_out; f0 = n_fd;
    send_frame(0); drain();
    check("t6_count", n_out - n0, 4);
    check("t6_fd", n_fd - f0, 1);
    foreach (got_q[i]) check("t6_val", {16'd0, got_q[i]}, 32'h3C00);

    // 7: random data, random idles and random backpressure over several frames.
    rdy_mode = 1; n0 = n_out; f0 = n_fd;
    for (int f = 0; f < 8; f++) begin
      foreach (fr[i]) fr[i] = rand_px();
      send_frame(30);
    end
    drain();
    rdy_mode = 0;
    check("t7_count", n_out - n0, 32);
    check("t7_fd", n_fd - f0, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/avgpool2x2_ctrl.md
Name: avgpool2x2_ctrl

Overview:
- Sequences the shared combinational FP16 `avg` unit (inputs a, b, c, d; output avgout) to perform 2x2 stride-2 average pooling on one feature-map channel.
- Accepts FP16 pixels in raster order over a valid/ready stream.
- Buffers one even row, assembles each 2x2 window, and drives the four operands into `avg`.
- Registers the pooled result onto an output valid/ready stream.
- Sits between a conv layer's output stream and the next layer's input buffer.

Parameters:
- DATA_W, 16, pixel width (IEEE FP16); must equal 16.
- IMG_W, 24, input row length in pixels; must be even and >= 2.
- IMG_H, 24, input rows per frame; must be even and >= 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  DATA_W  input pixel, FP16.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- out_data  out  DATA_W  pooled pixel, FP16.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- frame_done  out  1  one-cycle pulse when the final output of a frame is accepted.

Behaviour:
- Reset: rst_n is asynchronous, active-low; all state is cleared while it is low.
  - Reset values: out_valid=0, out_data=0, frame_done=0, col=0, row=0, hold=0.
  - in_ready is 0 while rst_n=0 and 1 after release.
  - Row buffer contents are don't-care after reset.
  - Reset mid-frame discards the partial frame; the next accepted pixel is treated as (row 0, col 0).
- Handshake: a transfer occurs on a cycle where valid && ready. Data is never dropped or duplicated.
  - in_ready = !out_valid || out_ready (global stall, independent of pixel position).
  - out_data is held stable while out_valid && !out_ready.
- Counters: col runs 0..IMG_W-1 and row runs 0..IMG_H-1. Both advance only on an accepted input.
  - col wraps to 0 at IMG_W-1 and row increments.
  - At (IMG_H-1, IMG_W-1), both wrap to 0 and a new frame begins.
- Phase state, derived from row[0] and col[0]:
  - EVEN_ROW (row even): the accepted pixel is written to rowbuf[col]. No output.
  - ODD_ROW, col even: the accepted pixel is latched into the hold register. No output.
  - ODD_ROW, col odd: window fire. The `avg` inputs are driven a=rowbuf[col-1], b=rowbuf[col], c=hold, d=in_data. avgout is registered into out_data and out_valid is set on the next clock edge.
- Latency: out_valid rises 1 cycle after the window-completing pixel is accepted.
- Throughput: 1 input per cycle sustained when out_ready=1. Each frame yields (IMG_W/2)*(IMG_H/2) outputs, in raster order of pooled coordinates.
- Output register:
  - Set on window fire.
  - Cleared on out_valid && out_ready unless a new window fires in the same cycle, in which case it reloads (fire wins).
- frame_done: pulses for 1 cycle in the cycle after the last pooled output of a frame is accepted, i.e. the acceptance of output index (IMG_W/2)*(IMG_H/2)-1.
  - A separate output counter tracks this.
  - The output counter wraps to 0 with the pulse.
- Arithmetic: the result is exactly avgout of the `avg` instance. No rounding is performed in this block.
  - rowbuf and hold store raw 16-bit patterns. NaN and Inf pass through to `avg` unmodified.
- Elaboration: IMG_W or IMG_H odd, or DATA_W != 16, is a fatal error.

Decomposition:
- Shared package (cnn_pkg): FP16 width constant, FP16 constants FP16_ZERO=16'h0000 and FP16_ONE=16'h3C00, and a helper for the counter width $clog2(IMG_W) / $clog2(IMG_H).
- Sub-modules:
  - Instantiates the existing `avg` module (positional order a, b, c, d, avgout) as the only arithmetic.
  - The row buffer is natural as one sub-module, line_buf_1r1w (IMG_W x DATA_W, 1 write port, 2 combinational read ports at col-1 and col).

Test Plan:
- 4x4 frame (IMG_W=IMG_H=4) of all 16'h3C00, out_ready=1 -> 4 outputs of 16'h3C00, each 1 cycle after pixels (1,1), (1,3), (3,1), (3,3); frame_done pulses once after the 4th.
- 4x4 frame, top-left window 1.0/2.0/3.0/4.0 (3C00, 4000, 4200, 4400), rest 0 -> out[0]=16'h4100 (2.5), out[1..3]=16'h0000.
- Window 39D2/35A1/B0A3/475E -> out_data bit-equal to a standalone `avg` instance given the same 4 operands (≈16'h4027).
- Backpressure: out_ready=0 for 5 cycles while out_valid=1 -> in_ready=0, out_data stable, no input lost; with out_ready restored, sequence and count match the no-stall run.
- Back-to-back 2 frames with in_valid=1 continuously -> 8 outputs in order, frame_done pulses exactly twice, second-frame values unaffected by first-frame rowbuf contents.
- Assert rst_n=0 at row 1 col 2 of a frame, release, then send a fresh all-3C00 frame -> out_valid low during reset, exactly 4 outputs of 3C00, no stale window emitted.
